// File: rtl/led_panel_receiver.sv
// HUB75-style LED panel bus receiver: samples the panel bus, rebuilds one 64-column row
// and decodes FM6126 register writes from latch pulse lengths.
module led_panel_receiver #(
    parameter int unsigned MIN_OVERSAMPLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] LED_PANEL,
    input  logic [5:0]  rd_x,
    output logic [2:0]  rd_rgb0,
    output logic [2:0]  rd_rgb1,
    output logic [4:0]  row_addr,
    output logic        row_valid,
    output logic        err_cols,
    output logic        err_latch,
    output logic [15:0] reg1,
    output logic [15:0] reg2,
    output logic [1:0]  reg_wr,
    output logic        blank_q
);

    localparam int unsigned NCOLS   = 64;
    localparam int unsigned PIX_W   = 6;
    localparam int unsigned REG_W   = 16;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned LAT_W   = 5;
    localparam int unsigned LAT_REG1 = 11;
    localparam int unsigned LAT_REG2 = 12;

    if (MIN_OVERSAMPLE < 2) begin : g_param_check
        $error("MIN_OVERSAMPLE must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        s1;
    logic [15:0]        s2;
    logic [15:0]        s2_d;
    logic [PIX_W-1:0]   shift_buf [NCOLS];
    logic [PIX_W-1:0]   lat_buf   [NCOLS];
    logic [REG_W-1:0]   reg_sr;
    logic [COL_W-1:0]   col_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               sclk_rise_c;
    logic               latch_rise_c;
    logic               latch_fall_c;
    logic               eval_c;
    logic [4:0]         addr_s;
    logic [PIX_W-1:0]   pix_s;
    logic               unused_bits;

    assign sclk_rise_c  = s2[14] & ~s2_d[14];
    assign latch_rise_c = s2[13] & ~s2_d[13];
    assign latch_fall_c = ~s2[13] & s2_d[13];
    assign addr_s       = {s2[15], s2[11:8]};
    assign pix_s        = {s2[6:4], s2[2:0]};
    assign blank_q      = s2[12];
    assign unused_bits  = ^{s2[3], s2[7], s2_d[15], s2_d[12:0]};

    assign rd_rgb0 = lat_buf[rd_x][2:0];
    assign rd_rgb1 = lat_buf[rd_x][5:3];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; eval_c marks the cycle a latch pulse is judged
    always_comb begin
        state_d = state_q;
        eval_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (latch_rise_c) begin
                    state_d = LATCH;
                end else if (sclk_rise_c && !s2[13]) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (latch_rise_c) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (latch_fall_c) begin
                    eval_c  = 1'b1;
                    state_d = sclk_rise_c ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizer, shift path, counters and latch evaluation
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            s2_d      <= '0;
            shift_buf <= '{default: '0};
            lat_buf   <= '{default: '0};
            reg_sr    <= '0;
            col_cnt   <= '0;
            lat_cnt   <= '0;
            row_addr  <= '0;
            reg1      <= '0;
            reg2      <= '0;
            row_valid <= 1'b0;
            err_cols  <= 1'b0;
            err_latch <= 1'b0;
            reg_wr    <= '0;
        end else begin
            s1        <= LED_PANEL;
            s2        <= s1;
            s2_d      <= s2;
            row_valid <= 1'b0;
            err_cols  <= 1'b0;
            err_latch <= 1'b0;
            reg_wr    <= '0;

            if (sclk_rise_c) begin
                for (int i = 0; i < NCOLS - 1; i++) begin
                    shift_buf[i] <= shift_buf[i+1];
                end
                shift_buf[NCOLS-1] <= pix_s;
                reg_sr <= {reg_sr[REG_W-2:0], s2[0]};
            end

            if (eval_c) begin
                // A coincident sclk rise belongs to the next row
                col_cnt <= sclk_rise_c ? COL_W'(1) : '0;
                lat_cnt <= '0;
                case (lat_cnt)
                    LAT_W'(0): begin
                        lat_buf   <= shift_buf;
                        row_addr  <= addr_s;
                        row_valid <= 1'b1;
                        err_cols  <= (col_cnt != COL_W'(NCOLS));
                    end
                    LAT_W'(LAT_REG1): begin
                        reg1   <= reg_sr;
                        reg_wr <= 2'b01;
                    end
                    LAT_W'(LAT_REG2): begin
                        reg2   <= reg_sr;
                        reg_wr <= 2'b10;
                    end
                    default: err_latch <= 1'b1;
                endcase
            end else if (sclk_rise_c) begin
                if (s2[13]) begin
                    if (lat_cnt != '1) lat_cnt <= lat_cnt + LAT_W'(1);
                end else begin
                    if (col_cnt != '1) col_cnt <= col_cnt + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_panel_receiver.sv
// Randomized bench for led_panel_receiver: a panel-driver model feeds the bus, a reference
// model predicts each latch outcome, and a monitor checks pulses and the latched row.
module tb_led_panel_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] LED_PANEL;
    logic [5:0]  rd_x;
    logic [2:0]  rd_rgb0, rd_rgb1;
    logic [4:0]  row_addr;
    logic        row_valid, err_cols, err_latch, blank_q;
    logic [15:0] reg1, reg2;
    logic [1:0]  reg_wr;

    led_panel_receiver #(.MIN_OVERSAMPLE(4)) dut (
        .clk(clk), .reset(reset), .LED_PANEL(LED_PANEL), .rd_x(rd_x),
        .rd_rgb0(rd_rgb0), .rd_rgb1(rd_rgb1), .row_addr(row_addr),
        .row_valid(row_valid), .err_cols(err_cols), .err_latch(err_latch),
        .reg1(reg1), .reg2(reg2), .reg_wr(reg_wr), .blank_q(blank_q)
    );

    always #100 clk = ~clk;

    // Panel driver levels
    logic [2:0] d_rgb0 = '0, d_rgb1 = '0;
    logic [4:0] d_addr = '0;
    logic       d_sclk = 1'b0, d_latch = 1'b0, d_blank = 1'b0;
    logic [1:0] d_junk = '0;
    assign LED_PANEL = {d_addr[4], d_sclk, d_latch, d_blank, d_addr[3:0],
                        d_junk[1], d_rgb1, d_junk[0], d_rgb0};

    typedef struct {
        logic        rv, ec, el;
        logic [1:0]  rw;
        logic [4:0]  ra;
        logic [15:0] r1, r2;
        logic [5:0]  pix [64];
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: full shift history, counts since the last latch, register values
    logic [5:0]  hist[$];
    int          cols_m, lats_m;
    logic [15:0] rsr_m, reg1_m, reg2_m;
    logic [4:0]  raddr_m;
    logic [5:0]  lat_m [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 64; i++) begin
            hist.push_back(6'd0);
            lat_m[i] = 6'd0;
        end
        cols_m = 0; lats_m = 0;
        rsr_m = '0; reg1_m = '0; reg2_m = '0; raddr_m = '0;
    endtask

    task automatic model_shift(input logic [2:0] a, input logic [2:0] b);
        hist.push_back({b, a});
        void'(hist.pop_front());
        rsr_m = {rsr_m[14:0], a[0]};
        if (d_latch) lats_m++;
        else         cols_m++;
    endtask

    task automatic model_eval();
        exp_t e;
        e.rv = 1'b0; e.ec = 1'b0; e.el = 1'b0; e.rw = 2'b00;
        if (lats_m == 0) begin
            for (int i = 0; i < 64; i++) lat_m[i] = hist[i];
            raddr_m = d_addr;
            e.rv = 1'b1;
            e.ec = (cols_m != 64);
        end else if (lats_m == 11) begin
            reg1_m = rsr_m; e.rw = 2'b01;
        end else if (lats_m == 12) begin
            reg2_m = rsr_m; e.rw = 2'b10;
        end else begin
            e.el = 1'b1;
        end
        e.ra = raddr_m; e.r1 = reg1_m; e.r2 = reg2_m;
        for (int i = 0; i < 64; i++) e.pix[i] = lat_m[i];
        sb.push_back(e);
        cols_m = 0; lats_m = 0;
    endtask

    // One panel clock: data set with sclk low, then sclk rises (4 clk per sclk)
    task automatic col(input logic [2:0] a, input logic [2:0] b);
        d_sclk = 1'b0; d_rgb0 = a; d_rgb1 = b; d_junk = 2'($urandom);
        repeat (2) @(negedge clk);
        d_sclk = 1'b1; model_shift(a, b);
        repeat (2) @(negedge clk);
    endtask

    task automatic col_latch_rise(input logic [2:0] a, input logic [2:0] b);
        d_sclk = 1'b0; d_rgb0 = a; d_rgb1 = b;
        repeat (2) @(negedge clk);
        d_sclk = 1'b1; d_latch = 1'b1; model_shift(a, b);
        repeat (2) @(negedge clk);
    endtask

    task automatic col_latch_fall(input logic [2:0] a, input logic [2:0] b);
        d_sclk = 1'b0; d_rgb0 = a; d_rgb1 = b;
        repeat (2) @(negedge clk);
        d_sclk = 1'b1; d_latch = 1'b0; model_eval(); model_shift(a, b);
        repeat (2) @(negedge clk);
    endtask

    task automatic latch_end();
        d_sclk = 1'b0; d_latch = 1'b0; model_eval();
        repeat (24) @(negedge clk);
    endtask

    task automatic row_latch();
        d_sclk = 1'b0; d_latch = 1'b1;
        repeat (3) @(negedge clk);
        latch_end();
    endtask

    task automatic pattern_cols(input int n);
        for (int x = 0; x < n; x++) begin
            logic [5:0] xv;
            xv = 6'(x);
            col(xv[2:0], ~xv[2:0]);
        end
    endtask

    task automatic reg_write(input logic [15:0] v, input int lat_len);
        for (int i = 0; i < 64; i++) begin
            if (i == 64 - lat_len) d_latch = 1'b1;
            col({2'($urandom), v[15 - (i % 16)]}, 3'($urandom));
        end
        latch_end();
    endtask

    task automatic do_reset();
        d_sclk = 1'b0; d_latch = 1'b0;
        reset = 1'b1; model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: pops an expectation for every pulse and sweeps the latched row
    exp_t me;
    initial begin
        rd_x = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && (row_valid || err_cols || err_latch || reg_wr != 2'b00)) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pulse: rv=%b ec=%b el=%b rw=%b with nothing expected",
                             row_valid, err_cols, err_latch, reg_wr);
                end else begin
                    me = sb.pop_front();
                    check("row_valid", 32'(row_valid), 32'(me.rv));
                    check("err_cols",  32'(err_cols),  32'(me.ec));
                    check("err_latch", 32'(err_latch), 32'(me.el));
                    check("reg_wr",    32'(reg_wr),    32'(me.rw));
                    check("row_addr",  32'(row_addr),  32'(me.ra));
                    check("reg1",      32'(reg1),      32'(me.r1));
                    check("reg2",      32'(reg2),      32'(me.r2));
                    for (int x = 0; x < 64; x++) begin
                        rd_x = 6'(x);
                        #1;
                        check("rd_rgb0", 32'(rd_rgb0), 32'(me.pix[x][2:0]));
                        check("rd_rgb1", 32'(rd_rgb1), 32'(me.pix[x][5:3]));
                    end
                end
            end
        end
    end

    initial begin
        #15_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        d_blank = 1'b1;
        repeat (3) @(negedge clk);
        check("blank_in_reset", 32'(blank_q), 32'(0));
        d_blank = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);

        check("rst_row_valid", 32'(row_valid), 32'(0));
        check("rst_row_addr",  32'(row_addr),  32'(0));
        check("rst_reg1",      32'(reg1),      32'(0));
        check("rst_reg2",      32'(reg2),      32'(0));
        check("rst_reg_wr",    32'(reg_wr),    32'(0));
        check("rst_errs",      32'({err_cols, err_latch}), 32'(0));
        check("rst_rgb",       32'({rd_rgb0, rd_rgb1}),    32'(0));

        d_blank = 1'b1;
        repeat (4) @(negedge clk);
        check("blank_high", 32'(blank_q), 32'(1));
        d_blank = 1'b0;
        repeat (4) @(negedge clk);
        check("blank_low", 32'(blank_q), 32'(0));

        // Full row, addr 5
        d_addr = 5'd5;
        pattern_cols(64);
        row_latch();

        // Register writes
        reg_write(16'h7FFF, 11);
        reg_write(16'h0040, 12);

        // Short and long rows, counter saturation
        pattern_cols(63);
        row_latch();
        d_addr = 5'd17;
        pattern_cols(70);
        row_latch();
        pattern_cols(192);
        row_latch();

        // Illegal latch length
        d_latch = 1'b1;
        for (int i = 0; i < 5; i++) col(3'($urandom), 3'($urandom));
        latch_end();

        // sclk rise coincident with latch rise, then with latch fall
        for (int i = 0; i < 53; i++) col({2'b00, 1'($urandom)}, 3'($urandom));
        col_latch_rise(3'($urandom), 3'($urandom));
        for (int i = 0; i < 10; i++) col(3'($urandom), 3'($urandom));
        latch_end();
        pattern_cols(64);
        d_sclk = 1'b0; d_latch = 1'b1;
        repeat (3) @(negedge clk);
        col_latch_fall(3'($urandom), 3'($urandom));
        for (int i = 0; i < 63; i++) col(3'($urandom), 3'($urandom));
        row_latch();

        // Reset mid-row
        for (int i = 0; i < 30; i++) col(3'($urandom), 3'($urandom));
        do_reset();
        d_addr = 5'd9;
        for (int i = 0; i < 64; i++) col(3'($urandom), 3'($urandom));
        row_latch();

        // Random rows with random blank
        for (int r = 0; r < 32; r++) begin
            d_addr = 5'($urandom);
            for (int c = 0; c < 64; c++) begin
                d_blank = 1'($urandom);
                col(3'($urandom), 3'($urandom));
            end
            row_latch();
        end
        d_blank = 1'b0;

        for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_panel_receiver.md
LED_PANEL_RECEIVER -- requirements
Module: led_panel_receiver

Interface
REQ-001 The block SHALL have parameter MIN_OVERSAMPLE, default 4, meaning the minimum ratio of clk frequency to panel sclk frequency the block supports (documentation only; no logic effect).
REQ-002 The block SHALL have ports, clock and reset first, as follows:
- clk, input, 1, receiver clock, asynchronous to the panel driver.
- reset, input, 1, synchronous, active-high.
- LED_PANEL, input, 16, panel bus.
- rd_x, input, 6, column index into the latched row.
- rd_rgb0, output, 3, latched upper-half pixel {r,g,b} at rd_x.
- rd_rgb1, output, 3, latched lower-half pixel at rd_x.
- row_addr, output, 5, address captured at the last row latch.
- row_valid, output, 1, one-cycle pulse when a row latch completes.
- err_cols, output, 1, one-cycle pulse when the column count at a row latch is not 64.
- err_latch, output, 1, one-cycle pulse on a latch pulse of illegal length.
- reg1, output, 16, last FM6126 REG1 value written.
- reg2, output, 16, last FM6126 REG2 value written.
- reg_wr, output, 2, one-cycle pulse; bit0 = REG1 written, bit1 = REG2 written.
- blank_q, output, 1, synchronized blank level.
REQ-003 The LED_PANEL bit map SHALL be as follows:
- [0]=r0, [1]=g0, [2]=b0, [3] ignored.
- [4]=r1, [5]=g1, [6]=b1, [7] ignored.
- [11:8]=addr[3:0], [15]=addr[4].
- [12]=blank, [13]=latch, [14]=sclk.

Function
REQ-004 All 16 LED_PANEL bits SHALL pass through a 2-flop synchronizer; all decoding SHALL use the second stage (s2), plus one extra registered copy of s2 for edge detection.
REQ-005 An sclk rising edge SHALL be detected when sclk s2=1 and its previous registered value is 0; rgb0/rgb1/addr SHALL be taken from s2 in that same cycle.
REQ-006 On each sclk rise, the 64-entry x 6-bit shift buffer SHALL shift by one:
- The new column enters entry 63 and the older entries move toward entry 0.
- After exactly 64 shifts, the first-shifted column sits at entry 0, i.e. x=0.
REQ-007 On each sclk rise, a 16-bit reg shift register SHALL shift in r0 at bit0; r0 shifted first ends up as the MSB.
REQ-008 The column counter col_cnt (7 bits) SHALL increment on each sclk rise while latch=0, and SHALL saturate at 127.
REQ-009 The latch-clock counter lat_cnt (5 bits) SHALL increment on each sclk rise while latch=1, and SHALL saturate at 31.
REQ-010 The block SHALL implement a state machine with states IDLE, SHIFT and LATCH:
- IDLE -> SHIFT on an sclk rise with latch=0.
- IDLE or SHIFT -> LATCH on a latch rising edge.
- LATCH -> IDLE on a latch falling edge, after evaluation per REQ-011.
- Evaluation clears col_cnt and lat_cnt.
REQ-011 On a latch falling edge, the block SHALL act on lat_cnt as follows:
- 0: row latch. Copy the shift buffer to the latched buffer, set row_addr to addr s2, pulse row_valid, and pulse err_cols if col_cnt!=64.
- 11: set reg1 to the reg shift register and pulse reg_wr[0].
- 12: set reg2 to the reg shift register and pulse reg_wr[1].
- Any other value: pulse err_latch; the latched buffer, row_addr and reg1/reg2 are unchanged.
REQ-012 For a register write, col_cnt counts only the latch-low columns; err_cols SHALL NOT fire on register writes.
REQ-013 All output pulses SHALL assert in the cycle after the latch falling edge is detected in s2, and SHALL last exactly one clk cycle.
REQ-014 rd_rgb0/rd_rgb1 SHALL be a combinational read of the latched buffer at rd_x; the latched buffer SHALL change only per REQ-011.
REQ-015 Simultaneous sclk rise and latch rise: the shift SHALL be counted in lat_cnt, not col_cnt.
REQ-016 Simultaneous sclk rise and latch fall: the shift SHALL be counted in col_cnt of the next row, after evaluation.
REQ-017 More than 64 shifts SHALL keep only the last 64 columns, and pulse err_cols at the row latch.
REQ-018 blank_q SHALL equal blank s2.
REQ-019 Blank SHALL NOT affect shifting or latching.

Reset
REQ-020 Synchronous reset SHALL clear the following: synchronizers, shift and latched buffers, the reg shift register, col_cnt, lat_cnt, row_addr, reg1, reg2, and all pulses; blank_q SHALL be 0 while reset is asserted and follow REQ-018 thereafter; state SHALL be IDLE.
REQ-021 Reset asserted mid-row or mid-register-write SHALL discard the partial data; the next latch after reset SHALL be evaluated on post-reset counts only.

Verification
REQ-022 Bench SHALL cover 64 columns where column x has rgb0=x[2:0] and rgb1=~x[2:0], with addr=5 and a latch with no clocks -> row_valid=1, row_addr=5, rd_x=9 gives rd_rgb0=1 and rd_rgb1=6, err_cols=0.
REQ-023 Bench SHALL cover 64 shifts of 16'h7FFF MSB-first on r0, with latch high for the last 11 -> reg1=16'h7FFF, reg_wr=01; then 16'h0040 with latch high for 12 -> reg2=16'h0040, reg_wr=10.
REQ-024 Bench SHALL cover 63 columns then a row latch -> row_valid=1 and err_cols=1; then 70 columns then a row latch -> err_cols=1 and rd_x=0 gives column 6.
REQ-025 Bench SHALL cover latch high for 5 sclk edges -> err_latch=1, reg1/reg2 unchanged, row_valid=0.
REQ-026 Bench SHALL cover reset after 30 columns, then 64 columns and a latch -> err_cols=0, with data equal to the post-reset columns.
REQ-027 Bench SHALL cover clk=4x sclk with random rgb/addr across 32 rows -> every rd_rgb matches the driven pattern.
